path_delay_accum: RTL
=====================

# path_delay_accum

Hardware timing-path evaluator for the cell library's arc delays. It holds a loadable table of pin-to-output arc delays indexed by cell type and input pin, with delays stored as integers in units of 0.01 ps (0.09387 ns = 9387). It consumes a stream of arcs that describes one timing path and returns the summed path delay, arc count and status flags through a valid/ready result port. The library loader writes the table; static-timing sequencing logic sits upstream of the arc stream and downstream of the result port.

## Interface
- CELL_W, 7, cell-type index width (up to 128 cell types)
- PIN_W, 3, input-pin index width (up to 8 pins per cell)
- DW, 16, stored delay width (unsigned)
- ACC_W, 24, accumulated path delay width (unsigned)

- CK  in  1  clock, rising edge
- RN  in  1  reset, synchronous, active-low
- ld_en  in  1  table write strobe
- ld_cell  in  CELL_W  write cell index
- ld_pin  in  PIN_W  write pin index
- ld_delay  in  DW  delay to store
- arc_valid  in  1  arc offered
- arc_ready  out  1  arc accepted when arc_valid & arc_ready
- arc_cell  in  CELL_W  arc cell index
- arc_pin  in  PIN_W  arc pin index
- arc_last  in  1  final arc of the path
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid & res_ready
- res_delay  out  ACC_W  path delay sum
- res_count  out  8  arcs in path, saturating at 255
- res_miss  out  1  at least one arc hit an unloaded entry (that arc contributes 0)
- res_ovf  out  1  res_delay saturated

## Operation
- Table: 2^(CELL_W+PIN_W) entries of DW bits plus a per-entry valid bit. Synchronous read, 1-cycle latency. Valid bits clear on reset; data is not reset.
- Load: when ld_en=1, the entry at {ld_cell,ld_pin} is written and marked valid at the edge. Loads are accepted in any state. A delay of 0 is legal and is marked valid.
- Same-cycle load and lookup to one address: read-first. The lookup returns the previous data and previous valid bit.
- FSM states: RUN, DRAIN, OUT.
  - RUN: arc_ready=1. Each accepted arc issues a lookup. Lookup data is added into the accumulator one cycle later. Throughput is one arc per cycle.
  - Accepted arc with arc_last=1 -> DRAIN.
  - DRAIN: arc_ready=0. The final lookup is added. -> OUT.
  - OUT: res_valid=1, and outputs are held stable until res_ready=1. On the transfer, return to RUN and clear accumulator, count and flags.
- Arithmetic: the accumulator is ACC_W bits and saturates at 2^ACC_W-1, setting ovf; once set it stays set for that path. Count saturates at 255. miss is the sticky OR of the inverted valid bits over the path.
- A path may be a single arc (arc_last on the first arc).
- arc_valid/arc_cell/arc_pin/arc_last must be held stable while arc_valid=1 and arc_ready=0.

## Timing
- Reset (RN=0 at an edge): state RUN; res_valid=0, res_delay=0, res_count=0, res_miss=0, res_ovf=0; all valid bits cleared. arc_ready is forced to 0 while RN=0 and is 1 in the first cycle after release.
- Reset mid-path or in OUT: the partial sum and the in-flight lookup are discarded. No result is produced.
- Latency: last arc accepted at the edge ending cycle t. Cycle t+1 is DRAIN. res_valid=1 from cycle t+2.
- Back-to-back: if res_ready=1 in cycle t+2, arc_ready=1 in cycle t+3. Minimum path period is N+2 cycles for N arcs.
- A load at the edge ending cycle t is visible to a lookup accepted in cycle t+1 or later.

## Test plan
- Load (cell 5, pin 0)=9387 and (cell 3, pin 1)=1502. Send path [5/0, 3/1 last] on consecutive cycles -> res_valid two cycles after the last accept, res_delay=10889, count=2, miss=0, ovf=0.
- Single arc, (cell 5, pin 0), last -> 9387, count=1. Then a path through unloaded (cell 9, pin 2) plus (cell 5, pin 0) -> 9387, miss=1.
- ACC_W=16, eight arcs each of delay 10000 -> res_delay=65535, ovf=1, count=8.
- Hold res_ready=0 for 5 cycles -> result stable, arc_ready=0 throughout. On release, a new path starts from 0: arc 1502 -> 1502.
- Same-cycle load of (cell 3, pin 1)=2000 and lookup of it (old 1502) -> that path sums 1502. The next path sums 2000.
- Reset after two of three arcs are accepted -> no res_valid. Table valid bits are clear, so a prior loaded entry now reports miss=1 and delay 0.

Source files
------------

// File: rtl/path_delay_accum.sv
// Timing-path evaluator: arc delay table lookup plus
// saturating path accumulator with a valid/ready result port.
module path_delay_accum #(
  parameter int CELL_W = 7,
  parameter int PIN_W  = 3,
  parameter int DW     = 16,
  parameter int ACC_W  = 24
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              ld_en,
  input  logic [CELL_W-1:0] ld_cell,
  input  logic [PIN_W-1:0]  ld_pin,
  input  logic [DW-1:0]     ld_delay,
  input  logic              arc_valid,
  output logic              arc_ready,
  input  logic [CELL_W-1:0] arc_cell,
  input  logic [PIN_W-1:0]  arc_pin,
  input  logic              arc_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_delay,
  output logic [7:0]        res_count,
  output logic              res_miss,
  output logic              res_ovf
);

  localparam int AW    = CELL_W + PIN_W;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    OUT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] vld;

  logic [AW-1:0] ld_addr;
  logic [AW-1:0] arc_addr;
  logic          accept;

  logic [DW-1:0] rd_data;
  logic          rd_vld;
  logic          pend;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nx;
  logic [7:0]       cnt;
  logic [7:0]       cnt_nx;
  logic             miss;
  logic             miss_nx;
  logic             ovf;
  logic             ovf_nx;

  logic [DW-1:0]  add_val;
  logic [ACC_W:0] sum;

  assign ld_addr  = {ld_cell, ld_pin};
  assign arc_addr = {arc_cell, arc_pin};

  assign arc_ready = RN & (state == RUN);
  assign accept    = arc_valid & arc_ready;

  // Data array is never reset; nonblocking
  // read gives read-first on address collision.
  always_ff @(posedge CK) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_delay;
    end
    if (accept) begin
      rd_data <= mem[arc_addr];
    end
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      vld    <= '0;
      rd_vld <= 1'b0;
      pend   <= 1'b0;
    end else begin
      if (ld_en) begin
        vld[ld_addr] <= 1'b1;
      end
      if (accept) begin
        rd_vld <= vld[arc_addr];
      end
      pend <= accept;
    end
  end

  assign add_val = rd_vld ? rd_data : '0;

  assign sum = {1'b0, acc}
             + {{(ACC_W + 1 - DW){1'b0}}, add_val};

  always_comb begin
    acc_nx  = acc;
    cnt_nx  = cnt;
    miss_nx = miss;
    ovf_nx  = ovf;
    if (pend) begin
      acc_nx  = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
      ovf_nx  = ovf | sum[ACC_W];
      miss_nx = miss | ~rd_vld;
      cnt_nx  = (&cnt) ? cnt : cnt + 8'd1;
    end
    if (state == OUT && res_ready) begin
      acc_nx  = '0;
      cnt_nx  = '0;
      miss_nx = 1'b0;
      ovf_nx  = 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN: begin
        if (accept && arc_last) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        state_nx = OUT;
      end
      OUT: begin
        if (res_ready) begin
          state_nx = RUN;
        end
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      state <= RUN;
      acc   <= '0;
      cnt   <= '0;
      miss  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      miss  <= miss_nx;
      ovf   <= ovf_nx;
    end
  end

  assign res_valid = (state == OUT);
  assign res_delay = acc;
  assign res_count = cnt;
  assign res_miss  = miss;
  assign res_ovf   = ovf;

endmodule
